// File: rtl/fp_to_int_pipe_pkg.sv
// Shared types for the bfloat16 -> int32/uint32 conversion pipeline.
// Holds the rounding-mode encoding, bf16 field widths and the stage-1 register layout.
package fp_to_int_pipe_pkg;

   typedef enum logic [1:0] {
      RNE = 2'b00,
      RTZ = 2'b01,
      RDN = 2'b10,
      RUP = 2'b11
   } fp_rnd_e;

   localparam int unsigned BF16_EXP_W = 8;
   localparam int unsigned BF16_MAN_W = 7;
   localparam int unsigned BF16_BIAS  = 127;

   // Zero and denormal operands share CLS_NUM; their magnitude is already zero.
   typedef enum logic [1:0] {
      CLS_NUM = 2'b00,
      CLS_INF = 2'b01,
      CLS_NAN = 2'b10,
      CLS_OVF = 2'b11
   } f2i_cls_e;

   typedef struct packed {
      logic        sign;
      f2i_cls_e    cls;
      logic        is_signed;
      fp_rnd_e     rnd_mode;
      logic [31:0] mag;
      logic        guard;
      logic        sticky;
   } f2i_s1_t;

endpackage

// File: rtl/fp_to_int_round.sv
// Stage-2 combinational round, saturate and negate for the bf16 -> integer path.
// Produces the final integer plus RISC-V fcvt invalid/inexact flags.
module fp_to_int_round
   import fp_to_int_pipe_pkg::*;
#(
   parameter int unsigned IntWidth = 32
) (
   input  f2i_s1_t              s1_i,
   output logic [IntWidth-1:0]  int_o,
   output logic                 nv_o,
   output logic                 nx_o
);

   logic        inc;
   logic        lost;
   logic [32:0] rounded;
   logic [31:0] res;
   logic        nv;

   always_comb begin
      lost = s1_i.guard | s1_i.sticky;
      inc  = 1'b0;
      unique case (s1_i.rnd_mode)
         RNE: inc = s1_i.guard & (s1_i.sticky | s1_i.mag[0]);
         RTZ: inc = 1'b0;
         RDN: inc = s1_i.sign & lost;
         RUP: inc = ~s1_i.sign & lost;
         default: inc = 1'b0;
      endcase
      rounded = {1'b0, s1_i.mag} + {32'd0, inc};

      res = '0;
      nv  = 1'b0;
      unique case (s1_i.cls)
         CLS_NAN: begin
            nv  = 1'b1;
            res = s1_i.is_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
         end
         CLS_INF, CLS_OVF: begin
            nv = 1'b1;
            if (s1_i.sign) res = s1_i.is_signed ? 32'h8000_0000 : 32'h0000_0000;
            else           res = s1_i.is_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
         end
         default: begin
            if (s1_i.is_signed) begin
               if (!s1_i.sign) begin
                  if (rounded > 33'h0_7FFF_FFFF) begin
                     nv  = 1'b1;
                     res = 32'h7FFF_FFFF;
                  end else begin
                     res = rounded[31:0];
                  end
               end else begin
                  if (rounded > 33'h0_8000_0000) begin
                     nv  = 1'b1;
                     res = 32'h8000_0000;
                  end else begin
                     res = 32'd0 - rounded[31:0];
                  end
               end
            end else begin
               if (!s1_i.sign) begin
                  if (rounded[32]) begin
                     nv  = 1'b1;
                     res = 32'hFFFF_FFFF;
                  end else begin
                     res = rounded[31:0];
                  end
               end else begin
                  // Negative values that round to zero are exact-or-inexact, never invalid.
                  nv  = (rounded != 33'd0);
                  res = 32'd0;
               end
            end
         end
      endcase

      int_o = res;
      nv_o  = nv;
      nx_o  = lost & ~nv;
   end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Two-stage bfloat16 -> int32/uint32 converter with valid/ready on both sides.
// Stage 1 decodes and aligns the operand; stage 2 registers the rounded result.
module fp_to_int_pipe
   import fp_to_int_pipe_pkg::*;
#(
   parameter int unsigned IntWidth = 32,
   parameter int unsigned FpWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [FpWidth-1:0]   fp_i,
   input  logic                 is_signed_i,
   input  logic [1:0]           rnd_mode_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [IntWidth-1:0]  int_o,
   output logic                 nv_o,
   output logic                 nx_o
);

   logic [BF16_EXP_W-1:0] exp_f;
   logic [BF16_MAN_W-1:0] man_f;
   logic signed [9:0]     e_unb;
   logic [38:0]           fx;
   f2i_s1_t               s1_d;
   f2i_s1_t               s1_q;
   logic                  s1_valid;
   logic                  s2_advance;
   logic [IntWidth-1:0]   rnd_int;
   logic                  rnd_nv;
   logic                  rnd_nx;

   assign s2_advance = ~out_valid_o | out_ready_i;
   assign in_ready_o = ~s1_valid | s2_advance;

   always_comb begin
      exp_f = fp_i[FpWidth-2 -: BF16_EXP_W];
      man_f = fp_i[BF16_MAN_W-1:0];
      e_unb = $signed({2'b00, exp_f}) - $signed(10'(BF16_BIAS));
      // 39-bit fixed point with 7 fraction bits: integer part lands in [38:7].
      fx    = {31'd0, 1'b1, man_f} << e_unb[4:0];

      s1_d           = '0;
      s1_d.sign      = fp_i[FpWidth-1];
      s1_d.is_signed = is_signed_i;
      s1_d.rnd_mode  = fp_rnd_e'(rnd_mode_i);
      s1_d.cls       = CLS_NUM;

      if (exp_f == '0) begin
         s1_d.sticky = (man_f != '0);
      end else if (exp_f == '1) begin
         s1_d.cls = (man_f == '0) ? CLS_INF : CLS_NAN;
      end else if (e_unb < 0) begin
         s1_d.guard  = (e_unb == -10'sd1);
         s1_d.sticky = ~((e_unb == -10'sd1) && (man_f == '0));
      end else if (e_unb > 10'sd31) begin
         s1_d.cls = CLS_OVF;
      end else begin
         s1_d.mag    = fx[38:7];
         s1_d.guard  = fx[6];
         s1_d.sticky = |fx[5:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_ready_o) begin
         s1_valid <= in_valid_i;
         if (in_valid_i) s1_q <= s1_d;
      end
   end

   fp_to_int_round #(
      .IntWidth (IntWidth)
   ) u_round (
      .s1_i  (s1_q),
      .int_o (rnd_int),
      .nv_o  (rnd_nv),
      .nx_o  (rnd_nx)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         int_o       <= '0;
         nv_o        <= 1'b0;
         nx_o        <= 1'b0;
      end else if (s2_advance) begin
         out_valid_o <= s1_valid;
         if (s1_valid) begin
            int_o <= rnd_int;
            nv_o  <= rnd_nv;
            nx_o  <= rnd_nx;
         end
      end
   end

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed self-checking bench for fp_to_int_pipe: conversions, streaming, stall and reset.
module tb_fp_to_int_pipe;

   logic        clk_i;
   logic        rst_ni;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] fp_i;
   logic        is_signed_i;
   logic [1:0]  rnd_mode_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] int_o;
   logic        nv_o;
   logic        nx_o;

   int errors = 0;
   int checks = 0;

   fp_to_int_pipe #(
      .IntWidth (32),
      .FpWidth  (16)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .fp_i        (fp_i),
      .is_signed_i (is_signed_i),
      .rnd_mode_i  (rnd_mode_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .int_o       (int_o),
      .nv_o        (nv_o),
      .nx_o        (nx_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic convert(input string tag, input logic [15:0] fp, input logic sg,
                          input logic [1:0] rm, input logic [31:0] ei,
                          input logic env, input logic enx);
      fp_i        = fp;
      is_signed_i = sg;
      rnd_mode_i  = rm;
      in_valid_i  = 1'b1;
      chk({tag, " in_ready"}, 32'(in_ready_o), 32'd1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      chk({tag, " early_valid"}, 32'(out_valid_o), 32'd0);
      @(posedge clk_i); #1;
      chk({tag, " valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, " int"}, int_o, ei);
      chk({tag, " nv"}, 32'(nv_o), 32'(env));
      chk({tag, " nx"}, 32'(nx_o), 32'(enx));
   endtask

   logic [15:0] tab [8];
   int          sent;
   int          got;
   logic        stalled_prev;
   logic [31:0] held;
   logic        saw_block;

   initial begin
      tab[0] = 16'h3F80; tab[1] = 16'h4000; tab[2] = 16'h4040; tab[3] = 16'h4080;
      tab[4] = 16'h40A0; tab[5] = 16'h40C0; tab[6] = 16'h40E0; tab[7] = 16'h4100;

      rst_ni      = 1'b0;
      in_valid_i  = 1'b0;
      fp_i        = 16'h0000;
      is_signed_i = 1'b1;
      rnd_mode_i  = 2'b00;
      out_ready_i = 1'b1;
      #22;
      chk("rst out_valid", 32'(out_valid_o), 32'd0);
      chk("rst int", int_o, 32'd0);
      chk("rst nv", 32'(nv_o), 32'd0);
      chk("rst nx", 32'(nx_o), 32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      convert("1.5 rne",     16'h3FC0, 1'b1, 2'b00, 32'd2,          1'b0, 1'b1);
      convert("1.5 rtz",     16'h3FC0, 1'b1, 2'b01, 32'd1,          1'b0, 1'b1);
      convert("-5 rne",      16'hC0A0, 1'b1, 2'b00, 32'hFFFF_FFFB,  1'b0, 1'b0);
      convert("0.5 rne",     16'h3F00, 1'b1, 2'b00, 32'd0,          1'b0, 1'b1);
      convert("0.5 rup",     16'h3F00, 1'b1, 2'b11, 32'd1,          1'b0, 1'b1);
      convert("-0.5 u rne",  16'hBF00, 1'b0, 2'b00, 32'd0,          1'b0, 1'b1);
      convert("-1 u",        16'hBF80, 1'b0, 2'b00, 32'd0,          1'b1, 1'b0);
      convert("-2^31 s",     16'hCF00, 1'b1, 2'b00, 32'h8000_0000,  1'b0, 1'b0);
      convert("2^31 s",      16'h4F00, 1'b1, 2'b00, 32'h7FFF_FFFF,  1'b1, 1'b0);
      convert("2^31 u",      16'h4F00, 1'b0, 2'b00, 32'h8000_0000,  1'b0, 1'b0);
      convert("nan s",       16'h7FC0, 1'b1, 2'b00, 32'h7FFF_FFFF,  1'b1, 1'b0);
      convert("nan u",       16'h7FC0, 1'b0, 2'b00, 32'hFFFF_FFFF,  1'b1, 1'b0);
      convert("-inf s",      16'hFF80, 1'b1, 2'b00, 32'h8000_0000,  1'b1, 1'b0);
      convert("+inf u",      16'h7F80, 1'b0, 2'b00, 32'hFFFF_FFFF,  1'b1, 1'b0);
      convert("denorm",      16'h0001, 1'b1, 2'b00, 32'd0,          1'b0, 1'b1);
      convert("-0",          16'h8000, 1'b1, 2'b10, 32'd0,          1'b0, 1'b0);
      convert("2^32 u ovf",  16'h4F80, 1'b0, 2'b01, 32'hFFFF_FFFF,  1'b1, 1'b0);
      convert("-2.5 rdn",    16'hC020, 1'b1, 2'b10, 32'hFFFF_FFFD,  1'b0, 1'b1);
      convert("2.5 rne",     16'h4020, 1'b1, 2'b00, 32'd2,          1'b0, 1'b1);

      // Back-to-back stream, consumer always ready.
      is_signed_i = 1'b1;
      rnd_mode_i  = 2'b01;
      out_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid_i = (c < 8);
         fp_i       = (c < 8) ? tab[c] : 16'h0000;
         if (c < 8) chk("stream in_ready", 32'(in_ready_o), 32'd1);
         @(posedge clk_i); #1;
         if (c >= 1 && c <= 8) begin
            chk("stream valid", 32'(out_valid_o), 32'd1);
            chk("stream int", int_o, 32'(c));
         end
      end
      in_valid_i = 1'b0;
      chk("stream drained", 32'(out_valid_o), 32'd0);

      // Consumer stalls for three cycles while the producer keeps offering.
      sent = 0; got = 0; stalled_prev = 1'b0; held = '0; saw_block = 1'b0;
      for (int c = 0; c < 30; c++) begin
         in_valid_i  = (sent < 8);
         fp_i        = (sent < 8) ? tab[sent] : 16'h0000;
         out_ready_i = !(c >= 2 && c <= 4);
         #1;
         if (stalled_prev) chk("stall hold", int_o, held);
         if (in_valid_i && !in_ready_o) saw_block = 1'b1;
         if (out_valid_o && out_ready_i) begin
            chk("stall order", int_o, 32'(got + 1));
            got++;
         end
         stalled_prev = out_valid_o && !out_ready_i;
         held         = int_o;
         if (in_valid_i && in_ready_o) sent++;
         @(posedge clk_i); #1;
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      chk("stall sent", 32'(sent), 32'd8);
      chk("stall got", 32'(got), 32'd8);
      chk("stall backpressure", 32'(saw_block), 32'd1);

      // Fill both stages, then reset mid-flight.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      fp_i        = tab[2];
      @(posedge clk_i); #1;
      fp_i        = tab[3];
      @(posedge clk_i); #1;
      in_valid_i  = 1'b0;
      chk("full valid", 32'(out_valid_o), 32'd1);
      chk("full in_ready", 32'(in_ready_o), 32'd0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midrst valid", 32'(out_valid_o), 32'd0);
      chk("midrst int", int_o, 32'd0);
      chk("midrst in_ready", 32'(in_ready_o), 32'd1);
      #2;
      rst_ni      = 1'b1;
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("postrst empty", 32'(out_valid_o), 32'd0);
      convert("postrst 1.5", 16'h3FC0, 1'b1, 2'b00, 32'd2, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
